frame_rx: RTL and testbench

FRAME_RX -- requirements
Module: frame_rx

---
 rtl/frame_rx_pkg.sv | 13 +
 rtl/frame_rx_fifo.sv | 49 ++++
 rtl/frame_rx.sv | 185 ++++++++++++++++++
 tb/tb_frame_rx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_rx_pkg.sv
// Shared types and default parameter values for the frame_rx receiver.
package frame_rx_pkg;

  typedef enum logic [1:0] {IDLE, DATA, PRTY, STOP} state_e;

  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_e;

  localparam int unsigned DEF_DATA_BITS      = 8;
  localparam parity_e     DEF_PARITY_MODE    = PAR_ODD;
  localparam int unsigned DEF_FIFO_DEPTH     = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 2000;

endpackage

// File: rtl/frame_rx_fifo.sv
// First-word-fall-through buffer; extra pointer bit distinguishes full from empty.
module frame_rx_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             wr_en, rd_en;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    rd_en    = pop && !empty;
    // When full, a simultaneous pop frees the head slot that the push then reuses.
    wr_en    = push && (!full || rd_en);
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rdata    = mem_q[rd_ptr_q[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/frame_rx.sv
// Clocked-serial frame receiver with synchronizers, parity/stop checking and a word buffer.
// Define FRAME_RX_TIMEOUT_EN to build the inter-edge timeout watchdog.
module frame_rx
  import frame_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS      = DEF_DATA_BITS,
  parameter parity_e     PARITY_MODE    = DEF_PARITY_MODE,
  parameter int unsigned FIFO_DEPTH     = DEF_FIFO_DEPTH,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                 sysclk,
  input  logic                 rst_n,
  input  logic                 clk,
  input  logic                 dat,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic                 err_start,
  output logic                 err_parity,
  output logic                 err_stop,
  output logic                 err_timeout,
  output logic                 err_overflow
);

  localparam int unsigned CW = $clog2(DATA_BITS);

  if (DATA_BITS < 5 || DATA_BITS > 16) begin : g_bad_bits
    $error("frame_rx: DATA_BITS out of range");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("frame_rx: FIFO_DEPTH must be a power of two in 2..16");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("frame_rx: TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]           clk_s_q, dat_s_q;
  logic                 clk_prev_q;
  logic                 bit_evt, dat_s;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 push, pop, full, empty;
  logic                 err_start_q, err_start_d;
  logic                 err_parity_q, err_parity_d;
  logic                 err_stop_q, err_stop_d;
  logic                 err_overflow_q, err_overflow_d;

  assign bit_evt = clk_prev_q && !clk_s_q[1];
  assign dat_s   = dat_s_q[1];
  assign pop     = rd_valid && rd_ready;

`ifdef FRAME_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_hit;
  logic          err_timeout_q, err_timeout_d;

  always_comb begin
    to_cnt_d = (state_q == IDLE || bit_evt) ? '0 : to_cnt_q + TW'(1);
    to_hit   = (state_q != IDLE) && !bit_evt && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q      <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      to_cnt_q      <= to_cnt_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign err_timeout = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    par_d          = par_q;
    push           = 1'b0;
    err_start_d    = 1'b0;
    err_parity_d   = 1'b0;
    err_stop_d     = 1'b0;
`ifdef FRAME_RX_TIMEOUT_EN
    err_timeout_d  = 1'b0;
`endif
    if (bit_evt) begin
      unique case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d = DATA;
            cnt_d   = '0;
            shift_d = '0;
            par_d   = 1'b0;
          end else begin
            err_start_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {dat_s, shift_q[DATA_BITS-1:1]};
          par_d   = par_q ^ dat_s;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CW'(DATA_BITS - 1))
            state_d = (PARITY_MODE == PAR_NONE) ? STOP : PRTY;
        end
        PRTY: begin
          if ((par_q ^ dat_s) == (PARITY_MODE == PAR_ODD)) begin
            state_d = STOP;
          end else begin
            state_d      = IDLE;
            err_parity_d = 1'b1;
          end
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s) push = 1'b1;
          else       err_stop_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef FRAME_RX_TIMEOUT_EN
    else if (to_hit) begin
      state_d       = IDLE;
      err_timeout_d = 1'b1;
    end
`endif
    err_overflow_d = push && full && !pop;
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s_q        <= '1;
      dat_s_q        <= '1;
      clk_prev_q     <= 1'b1;
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      err_start_q    <= 1'b0;
      err_parity_q   <= 1'b0;
      err_stop_q     <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      clk_s_q        <= {clk_s_q[0], clk};
      dat_s_q        <= {dat_s_q[0], dat};
      clk_prev_q     <= clk_s_q[1];
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      err_start_q    <= err_start_d;
      err_parity_q   <= err_parity_d;
      err_stop_q     <= err_stop_d;
      err_overflow_q <= err_overflow_d;
    end
  end

  assign err_start    = err_start_q;
  assign err_parity   = err_parity_q;
  assign err_stop     = err_stop_q;
  assign err_overflow = err_overflow_q;
  assign rd_valid     = !empty;

  frame_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sysclk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (rd_data),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_frame_rx.sv
// Directed bench for frame_rx: default instance (A) and a 12-bit even-parity instance (B).
module tb_frame_rx;
  import frame_rx_pkg::*;

  logic        sysclk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        clk_a = 1'b1, dat_a = 1'b1, rdy_a = 1'b0;
  logic        clk_b = 1'b1, dat_b = 1'b1, rdy_b = 1'b0;
  logic [7:0]  data_a;
  logic [11:0] data_b;
  logic        valid_a, valid_b;
  logic        es_a, ep_a, ec_a, et_a, eo_a;
  logic        es_b, ep_b, ec_b, et_b, eo_b;

  int vectors = 0;
  int miscompares = 0;
  int cnt_a[5] = '{default: 0};
  int cnt_b[5] = '{default: 0};
  int base_a[5] = '{default: 0};
  int base_b[5] = '{default: 0};

  always #5 sysclk = ~sysclk;

  frame_rx u_a (
    .sysclk(sysclk), .rst_n(rst_n), .clk(clk_a), .dat(dat_a),
    .rd_data(data_a), .rd_valid(valid_a), .rd_ready(rdy_a),
    .err_start(es_a), .err_parity(ep_a), .err_stop(ec_a),
    .err_timeout(et_a), .err_overflow(eo_a)
  );

  frame_rx #(.DATA_BITS(12), .PARITY_MODE(PAR_EVEN)) u_b (
    .sysclk(sysclk), .rst_n(rst_n), .clk(clk_b), .dat(dat_b),
    .rd_data(data_b), .rd_valid(valid_b), .rd_ready(rdy_b),
    .err_start(es_b), .err_parity(ep_b), .err_stop(ec_b),
    .err_timeout(et_b), .err_overflow(eo_b)
  );

  // Pulse counters: index 0 start, 1 parity, 2 stop, 3 timeout, 4 overflow.
  always @(negedge sysclk) begin
    cnt_a[0] <= cnt_a[0] + ((es_a === 1'b1) ? 1 : 0);
    cnt_a[1] <= cnt_a[1] + ((ep_a === 1'b1) ? 1 : 0);
    cnt_a[2] <= cnt_a[2] + ((ec_a === 1'b1) ? 1 : 0);
    cnt_a[3] <= cnt_a[3] + ((et_a === 1'b1) ? 1 : 0);
    cnt_a[4] <= cnt_a[4] + ((eo_a === 1'b1) ? 1 : 0);
    cnt_b[0] <= cnt_b[0] + ((es_b === 1'b1) ? 1 : 0);
    cnt_b[1] <= cnt_b[1] + ((ep_b === 1'b1) ? 1 : 0);
    cnt_b[2] <= cnt_b[2] + ((ec_b === 1'b1) ? 1 : 0);
    cnt_b[3] <= cnt_b[3] + ((et_b === 1'b1) ? 1 : 0);
    cnt_b[4] <= cnt_b[4] + ((eo_b === 1'b1) ? 1 : 0);
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    base_a = cnt_a;
    base_b = cnt_b;
  endtask

  task automatic check_errs(input int sel, input string tag, input logic [4:0] exp);
    for (int i = 0; i < 5; i++) begin
      if (sel == 0) check($sformatf("%s_err%0d", tag, i), 32'(cnt_a[i] - base_a[i]), 32'(exp[i]));
      else          check($sformatf("%s_err%0d", tag, i), 32'(cnt_b[i] - base_b[i]), 32'(exp[i]));
    end
  endtask

  task automatic drive(input int sel, input logic c, input logic d);
    if (sel == 0) begin clk_a = c; dat_a = d; end
    else          begin clk_b = c; dat_b = d; end
  endtask

  task automatic fall(input int sel, input logic b);
    @(negedge sysclk) drive(sel, 1'b1, b);
    repeat (3) @(negedge sysclk);
    drive(sel, 1'b0, b);
  endtask

  task automatic rise(input int sel, input logic b);
    repeat (4) @(negedge sysclk);
    drive(sel, 1'b1, b);
    repeat (3) @(negedge sysclk);
  endtask

  task automatic send_bit(input int sel, input logic b);
    fall(sel, b);
    rise(sel, b);
  endtask

  task automatic send_bits(input int sel, input int first, input int last, input logic [15:0] v);
    for (int i = first; i <= last; i++) send_bit(sel, v[i]);
  endtask

  task automatic send_frame(input int sel, input int n, input logic [15:0] v,
                            input logic p, input logic stop);
    send_bit(sel, 1'b0);
    send_bits(sel, 0, n - 1, v);
    send_bit(sel, p);
    send_bit(sel, stop);
  endtask

  task automatic pop_check(input int sel, input string tag, input logic [31:0] exp);
    @(negedge sysclk);
    if (sel == 0) begin
      check({tag, "_valid"}, 32'(valid_a), 32'd1);
      check({tag, "_data"}, 32'(data_a), exp);
      rdy_a = 1'b1;
    end else begin
      check({tag, "_valid"}, 32'(valid_b), 32'd1);
      check({tag, "_data"}, 32'(data_b), exp);
      rdy_b = 1'b1;
    end
    @(negedge sysclk);
    rdy_a = 1'b0;
    rdy_b = 1'b0;
  endtask

  initial begin
    logic [4:0]  ovf_par;
    logic [15:0] w;
    ovf_par = 5'b10100;
    w       = 16'h005A;

    repeat (3) @(negedge sysclk);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    check("rst_err_a", 32'({es_a, ep_a, ec_a, et_a, eo_a}), 32'd0);
    check("rst_err_b", 32'({es_b, ep_b, ec_b, et_b, eo_b}), 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);

    // Good frame 0x5A with odd parity 1; check latency around the stop edge.
    snap();
    send_bit(0, 1'b0);
    send_bits(0, 0, 7, 16'h005A);
    send_bit(0, 1'b1);
    fall(0, 1'b1);
    @(posedge sysclk) #1;
    @(posedge sysclk) #1;
    check("lat_before", 32'(valid_a), 32'd0);
    @(posedge sysclk) #1;
    check("lat_after", 32'(valid_a), 32'd1);
    check("lat_data", 32'(data_a), 32'h5A);
    rise(0, 1'b1);
    check_errs(0, "good5a", 5'b00000);
    pop_check(0, "pop5a", 32'h5A);
    check("empty_after_pop", 32'(valid_a), 32'd0);

    // Bad parity: word dropped, the trailing stop bit lands in IDLE as a start error.
    snap();
    send_frame(0, 8, 16'h005A, 1'b0, 1'b1);
    check_errs(0, "badpar", 5'b00011);
    check("badpar_valid", 32'(valid_a), 32'd0);
    send_frame(0, 8, 16'h003C, 1'b1, 1'b1);
    pop_check(0, "pop3c", 32'h3C);
    check_errs(0, "after3c", 5'b00011);

    // 12-bit even parity instance.
    snap();
    send_frame(1, 12, 16'h0ABC, 1'b1, 1'b1);
    check_errs(1, "b_good", 5'b00000);
    pop_check(1, "popabc", 32'hABC);
    snap();
    send_frame(1, 12, 16'h0ABC, 1'b1, 1'b0);
    check_errs(1, "b_stop", 5'b00100);
    check("b_stop_valid", 32'(valid_b), 32'd0);

    // Overflow: five words into a four-entry buffer with no consumer.
    snap();
    for (int v = 1; v <= 5; v++) send_frame(0, 8, 16'(v), ovf_par[v-1], 1'b1);
    check_errs(0, "ovf", 5'b10000);
    for (int v = 1; v <= 4; v++) pop_check(0, $sformatf("ovf_pop%0d", v), 32'(v));
    check("ovf_drained", 32'(valid_a), 32'd0);

    // Stall after three data bits.
    snap();
    send_bit(0, 1'b0);
    send_bits(0, 0, 2, w);
    repeat (2100) @(negedge sysclk);
`ifdef FRAME_RX_TIMEOUT_EN
    check_errs(0, "tmo", 5'b01000);
    check("tmo_valid", 32'(valid_a), 32'd0);
    send_frame(0, 8, w, 1'b1, 1'b1);
    pop_check(0, "tmo_next", 32'h5A);
    check_errs(0, "tmo_after", 5'b01000);
`else
    check_errs(0, "stall", 5'b00000);
    send_bits(0, 3, 7, w);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    pop_check(0, "resume", 32'h5A);
    check_errs(0, "resume_after", 5'b00000);
`endif

    // Reset mid-frame is silent; next frame received intact.
    snap();
    send_bit(0, 1'b0);
    send_bits(0, 0, 3, 16'h00FF);
    @(negedge sysclk) rst_n = 1'b0;
    repeat (2) @(negedge sysclk);
    rst_n = 1'b1;
    repeat (3) @(negedge sysclk);
    check_errs(0, "midrst", 5'b00000);
    check("midrst_valid", 32'(valid_a), 32'd0);
    send_frame(0, 8, 16'h00FF, 1'b1, 1'b1);
    pop_check(0, "popff", 32'hFF);
    check_errs(0, "after_ff", 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
